sccb_write_master: RTL and testbench

SCCB (I2C-compatible) 3-phase write master that drives the OV7670 configuration bus.
- Consumes 16-bit {register address, data} commands from the register LUT stage using the existing send/taken handshake.
- Serializes each command as device ID, register address and data on sioc/siod.
- Sits directly downstream of the register table, inside the camera configuration path.

---
 rtl/sccb_write_master.sv | 152 +++++++++++++++
 tb/tb_sccb_write_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: {DEVICE_ID, rega, value} serialized on sioc/siod.
// Define SCCB_ACK_CHECK_EN to sample the ACK slots into a sticky ack_err flag.
module sccb_write_master #(
  parameter int         CLK_FREQ_HZ  = 50000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter int         GAP_QUARTERS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] rega,
  input  logic [7:0] value,
  output logic       taken,
  output logic       busy,
  output logic       ack_err,
  output logic       sioc,
  inout  wire        siod
);

  localparam int DIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [CW-1:0] cnt;
  logic [26:0]   sh;
  logic          sda_low;
  logic          tick;
  logic          gap_done;
  logic          accept;

  assign tick     = (div_cnt == DW'(DIV - 1));
  assign gap_done = (state == S_GAP) && tick && (cnt == CW'(GAP_QUARTERS - 1));
  // Accepting on the final gap tick keeps back-to-back frames exactly one transaction apart.
  assign accept   = send && ((state == S_IDLE) || gap_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      q       <= '0;
      cnt     <= '0;
      sh      <= '0;
      taken   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (state != S_IDLE)
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (accept) begin
        // Slot positions carry 1 so siod is released there.
        sh      <= {DEVICE_ID, 1'b1, rega, 1'b1, value, 1'b1};
        taken   <= 1'b1;
        busy    <= 1'b1;
        div_cnt <= '0;
        q       <= '0;
        cnt     <= '0;
        state   <= S_START;
      end else if (tick) begin
        case (state)
          S_START: begin
            q <= q + 2'd1;
            if (q == 2'd3) state <= S_SHIFT;
          end
          S_SHIFT: begin
            q <= q + 2'd1;
            if (q == 2'd3) begin
              sh <= {sh[25:0], 1'b1};
              if (cnt == CW'(26)) begin
                cnt   <= '0;
                state <= S_STOP;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          S_STOP: begin
            q <= q + 2'd1;
            if (q == 2'd3) begin
              if (GAP_QUARTERS == 0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (cnt == CW'(GAP_QUARTERS - 1)) begin
              cnt   <= '0;
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  logic ack_slot;
  assign ack_slot = (state == S_SHIFT) &&
                    ((cnt == CW'(8)) || (cnt == CW'(17)) || (cnt == CW'(26)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ack_err <= 1'b0;
    else if (accept)
      ack_err <= 1'b0;
    else if (tick && ack_slot && (q == 2'd2) && siod)
      ack_err <= 1'b1;
  end
`else
  assign ack_err = 1'b0;
`endif

  always_comb begin
    sioc    = 1'b1;
    sda_low = 1'b0;
    case (state)
      S_START: begin
        sioc    = (q == 2'd0) || (q == 2'd1);
        sda_low = (q != 2'd0);
      end
      S_SHIFT: begin
        sioc    = (q == 2'd1) || (q == 2'd2);
        sda_low = !sh[26];
      end
      S_STOP: begin
        sioc    = (q != 2'd0);
        sda_low = (q == 2'd0) || (q == 2'd1);
      end
      default: ;
    endcase
  end

  // Open-drain: only ever pull low.
  assign siod = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master: bus monitor decodes frames and checks them against a scoreboard.
module tb_sccb_write_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       send = 1'b0;
  logic [7:0] rega = '0, value = '0;
  logic       taken, busy, ack_err, sioc;
  wire        siod;
  logic       ack_drive;
  pullup (siod);
  assign siod = ack_drive ? 1'b0 : 1'bz;

  logic       send2 = 1'b0;
  logic [7:0] rega2 = '0, value2 = '0;
  logic       taken2, busy2, ack_err2, sioc2;
  wire        siod2;
  pullup (siod2);

  sccb_write_master #(.CLK_FREQ_HZ(400), .SCCB_FREQ_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .rega(rega), .value(value),
    .taken(taken), .busy(busy), .ack_err(ack_err), .sioc(sioc), .siod(siod));

  sccb_write_master dut2 (
    .clk(clk), .rst_n(rst_n), .send(send2), .rega(rega2), .value(value2),
    .taken(taken2), .busy(busy2), .ack_err(ack_err2), .sioc(sioc2), .siod(siod2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int taken_cnt = 0;
  int frames = 0;

  logic [23:0] exp_q[$];

  bit          in_frame = 1'b0;
  int          nbits = 0;
  int          nfall = 0;
  logic [26:0] rx = '0;
  logic        psioc = 1'b1, psiod = 1'b1;
  bit          ack_mode = 1'b0;
  bit          skip17 = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (taken) taken_cnt++;
  end

  // Emulated slave ACK: pull low from the fall before a slot until the slot's own fall.
  always_comb
    ack_drive = ack_mode && in_frame &&
                ((nfall == 9) || (nfall == 18 && !skip17) || (nfall == 27));

  // Bus monitor on dut: start/stop detection, bit capture on sioc rise, scoreboard compare.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_frame = 1'b0;
      nbits = 0;
      nfall = 0;
    end else if (!in_frame) begin
      if (psioc && sioc && psiod === 1'b1 && siod === 1'b0) begin
        in_frame = 1'b1;
        nbits = 0;
        nfall = 0;
        rx = '0;
      end
    end else begin
      if (!psioc && sioc && nbits < 27) begin
        rx = {rx[25:0], siod};
        nbits++;
      end
      if (psioc && !sioc) nfall++;
      if (psioc && sioc && psiod !== siod) begin
        if (nbits == 27 && siod === 1'b1) begin
          logic [23:0] got, e;
          got = {rx[26:19], rx[17:10], rx[8:1]};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got %h, required no frame", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL frame_bytes: got %h, required %h", got, e);
            end
          end
          if (!ack_mode) begin
            checks++;
            if ({rx[18], rx[9], rx[0]} !== 3'b111) begin
              errors++;
              $display("FAIL ack_slots_released: got %b, required 111", {rx[18], rx[9], rx[0]});
            end
          end
          frames++;
          in_frame = 1'b0;
        end else begin
          checks++;
          errors++;
          $display("FAIL bus_edge: siod moved to %b with sioc high at bit %0d", siod, nbits);
        end
      end
    end
    psioc = sioc;
    psiod = siod;
  end

  task automatic wait_taken(input string name);
    int n = 0;
    while (!taken && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL %s: taken not seen within 400 clk", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || in_frame) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy || in_frame) begin
      errors++;
      $display("FAIL %s: still busy after 2000 clk", name);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input bit push);
    if (push) exp_q.push_back({8'h42, a, d});
    @(posedge clk); #1;
    send = 1'b1; rega = a; value = d;
    @(posedge clk); #1;
    wait_taken("run_frame_taken");
    send = 1'b0;
    wait_idle("run_frame_idle");
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (sioc !== 1'b1) begin errors++; $display("FAIL reset_sioc: got %b, required 1", sioc); end
    if (siod !== 1'b1) begin errors++; $display("FAIL reset_siod: got %b, required released(1)", siod); end
    if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b, required 0", taken); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b, required 0", ack_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int t0, f0, n;
    t0 = taken_cnt; f0 = frames;
    exp_q.push_back({8'h42, 8'h12, 8'h80});
    @(posedge clk); #1;
    send = 1'b1; rega = 8'h12; value = 8'h80;
    @(posedge clk); #1;
    checks++;
    if (taken !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL taken_latency: taken=%b busy=%b, required 1/1 one clk after send", taken, busy);
    end
    send = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 124) begin errors++; $display("FAIL busy_len: got %0d clk, required 124", n); end
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if (taken_cnt - t0 != 1) begin errors++; $display("FAIL taken_pulses: got %0d, required 1", taken_cnt - t0); end
    if (frames - f0 != 1) begin errors++; $display("FAIL single_frames: got %0d, required 1", frames - f0); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, f0, n;
    f0 = frames;
    exp_q.push_back({8'h42, 8'h12, 8'h80});
    @(posedge clk); #1;
    send = 1'b1; rega = 8'h12; value = 8'h80;
    @(posedge clk); #1;
    wait_taken("b2b_first_taken");
    c1 = cyc;
    rega = 8'h11; value = 8'h01;
    exp_q.push_back({8'h42, 8'h11, 8'h01});
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!taken && n < 400);
    c2 = cyc;
    send = 1'b0;
    checks += 2;
    if (c2 - c1 != 124) begin errors++; $display("FAIL b2b_spacing: got %0d clk, required 124", c2 - c1); end
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, required 1 across frames", busy); end
    wait_idle("b2b_idle");
    checks++;
    if (frames - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d, required 2", frames - f0); end
  endtask

  task automatic test_change_after_taken();
    int f0;
    f0 = frames;
    exp_q.push_back({8'h42, 8'hA5, 8'h3C});
    @(posedge clk); #1;
    send = 1'b1; rega = 8'hA5; value = 8'h3C;
    @(posedge clk); #1;
    wait_taken("chg_taken");
    send = 1'b0;
    @(posedge clk); #1;
    rega = 8'hFF; value = 8'h00;
    wait_idle("chg_idle");
    checks++;
    if (frames - f0 != 1) begin errors++; $display("FAIL chg_frames: got %0d, required 1", frames - f0); end
  endtask

  task automatic test_reset_mid();
    int n, f0;
    @(posedge clk); #1;
    send = 1'b1; rega = 8'h55; value = 8'hAA;
    @(posedge clk); #1;
    wait_taken("mid_taken");
    send = 1'b0;
    n = 0;
    while (!(in_frame && nbits >= 10) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (sioc !== 1'b1) begin errors++; $display("FAIL mid_reset_sioc: got %b, required 1", sioc); end
    if (siod !== 1'b1) begin errors++; $display("FAIL mid_reset_siod: got %b, required released(1)", siod); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    if (taken !== 1'b0) begin errors++; $display("FAIL mid_reset_taken: got %b, required 0", taken); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    run_frame(8'h12, 8'h34, 1'b1);
    checks++;
    if (frames - f0 != 1) begin errors++; $display("FAIL mid_restart_frames: got %0d, required 1", frames - f0); end
  endtask

  task automatic test_ack();
`ifdef SCCB_ACK_CHECK_EN
    ack_mode = 1'b1; skip17 = 1'b0;
    run_frame(8'h12, 8'h80, 1'b1);
    checks++;
    if (ack_err !== 1'b0) begin errors++; $display("FAIL ack_all_acked: got %b, required 0", ack_err); end
    skip17 = 1'b1;
    run_frame(8'h11, 8'h01, 1'b1);
    checks++;
    if (ack_err !== 1'b1) begin errors++; $display("FAIL ack_nack17: got %b, required 1", ack_err); end
    skip17 = 1'b0;
    exp_q.push_back({8'h42, 8'h13, 8'h02});
    @(posedge clk); #1;
    send = 1'b1; rega = 8'h13; value = 8'h02;
    @(posedge clk); #1;
    wait_taken("ack_clear_taken");
    send = 1'b0;
    checks++;
    if (ack_err !== 1'b0) begin errors++; $display("FAIL ack_clear_at_accept: got %b, required 0", ack_err); end
    wait_idle("ack_clear_idle");
    ack_mode = 1'b0;
`else
    run_frame(8'h12, 8'h80, 1'b1);
    checks++;
    if (ack_err !== 1'b0) begin errors++; $display("FAIL ack_tied_low: got %b, required 0", ack_err); end
`endif
  endtask

  task automatic test_default_div();
    int n, r1, r2, f1, nr;
    logic ps;
    @(posedge clk); #1;
    send2 = 1'b1; rega2 = 8'h12; value2 = 8'h80;
    @(posedge clk); #1;
    checks++;
    if (taken2 !== 1'b1) begin errors++; $display("FAIL div_taken: got %b, required 1", taken2); end
    send2 = 1'b0;
    n = 0; nr = 0; r1 = 0; r2 = 0; f1 = 0;
    ps = sioc2;
    while (busy2 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (!ps && sioc2) begin
        if (nr == 0) r1 = n;
        else if (nr == 1) r2 = n;
        nr++;
      end
      if (ps && !sioc2 && nr == 1 && f1 == 0) f1 = n;
      ps = sioc2;
    end
    checks += 4;
    if (f1 - r1 != 250) begin errors++; $display("FAIL div_high: got %0d clk, required 250", f1 - r1); end
    if (r2 - f1 != 250) begin errors++; $display("FAIL div_low: got %0d clk, required 250", r2 - f1); end
    if (r2 - r1 != 500) begin errors++; $display("FAIL div_period: got %0d clk, required 500", r2 - r1); end
    if (n != 15500) begin errors++; $display("FAIL div_busy_len: got %0d clk, required 15500", n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_change_after_taken();
    test_reset_mid();
    test_ack();
    test_default_div();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
